// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PARITY  = 2'd1;
  localparam logic [1:0] ERR_STOP    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Both PS/2 lines are open-collector and float high when idle.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Line inputs, FIFO read side and status outputs of the PS/2 receiver.
interface ps2_rx_fifo_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic              SCL;
    logic              SDA;
    logic              RD_EN;
    logic [DATA_W-1:0] RX_DATA;
    logic              DATA_VALID;
    logic [CW-1:0]     FIFO_COUNT;
    logic              FRAME_ERR;
    logic [1:0]        ERR_CODE;
    logic              OVERFLOW;

    // Device / consumer side.
    modport master (
        output SCL, SDA, RD_EN,
        input  RX_DATA, DATA_VALID, FIFO_COUNT, FRAME_ERR, ERR_CODE, OVERFLOW
    );

    // Receiver side.
    modport slave (
        input  SCL, SDA, RD_EN,
        output RX_DATA, DATA_VALID, FIFO_COUNT, FRAME_ERR, ERR_CODE, OVERFLOW
    );
endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a saturating glitch filter for one PS/2 line.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic in,
    output logic out
);
    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic          meta_q, sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
            filt_q <= LINE_IDLE;
            cnt_q  <= '0;
        end else begin
            meta_q <= in;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    // Output flips on the FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign out = filt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver in the system clock domain with framing checks and a FWFT byte FIFO.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    ps2_rx_fifo_if.slave bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic scl_f, sda_f;
    logic scl_prev_q;
    logic fall;

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .in    (bus.SCL),
        .out   (scl_f)
    );

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .in    (bus.SDA),
        .out   (sda_f)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) scl_prev_q <= LINE_IDLE;
        else       scl_prev_q <= scl_f;
    end

    assign fall = scl_prev_q & ~scl_f;

    // ---------------- frame FSM ----------------
    ps2_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic              par_q, par_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              push_q, push_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              timeout;
    logic              parity_ok;

    assign timeout   = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign parity_ok = ^{shift_q, par_q};

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:   if (!sda_f) state_d = DATA;
                DATA:   if (bitcnt_q == BW'(DATA_W - 1)) state_d = PARITY;
                PARITY: state_d = STOP;
                STOP:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        par_d       = par_q;
        tmo_d       = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        if (timeout) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    bitcnt_d = '0;
                    shift_d  = '0;
                end
                DATA: begin
                    shift_d[bitcnt_q] = sda_f;
                    bitcnt_d          = bitcnt_q + BW'(1);
                end
                PARITY: par_d = sda_f;
                STOP: begin
                    // Parity failure is reported even when the stop bit is also bad.
                    if (!parity_ok) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_PARITY;
                    end else if (!sda_f) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_STOP;
                    end else begin
                        push_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            shift_q     <= '0;
            bitcnt_q    <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // ---------------- FIFO ----------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q;
    logic              full, empty, pop, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = bus.RD_EN & ~empty;
    assign push_ok = push_q & (~full | pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= push_q & full & ~pop;
        end
    end

    // shift_q is stable for many cycles after the stop bit, so it is the write data.
    always_ff @(posedge CLOCK) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.RX_DATA    = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.DATA_VALID = ~empty;
    assign bus.FIFO_COUNT = count_q;
    assign bus.FRAME_ERR  = frame_err_q;
    assign bus.ERR_CODE   = err_code_q;
    assign bus.OVERFLOW   = ovf_q;

endmodule
